// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_e      : arbiter FSM state encoding
//   arb_port_e       : which requester owns the current grant
//   MAX_D_STREAK_DEF : default data grants allowed back-to-back while a fetch waits
//   TIMEOUT_DEF      : default cycles a grant waits for mem_ack before aborting
//   STREAK_W         : width of the fairness streak counter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_e;

  localparam int unsigned MAX_D_STREAK_DEF = 4;
  localparam int unsigned TIMEOUT_DEF      = 15;
  localparam int unsigned STREAK_W         = 3;

endpackage

// File: rtl/arb_fairness_ctr.sv
// Saturating count of data grants issued while a fetch was waiting.
//   clk, rst       : clock, asynchronous active-low reset
//   grant_i_entry  : FSM is entering a fetch grant this cycle
//   grant_d_entry  : FSM is entering a data grant this cycle
//   i_req          : fetch request level at the grant decision
//   streak         : current streak, saturates at MAX_D_STREAK
module arb_fairness_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                grant_i_entry,
  input  logic                grant_d_entry,
  input  logic                i_req,
  output logic [STREAK_W-1:0] streak
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  always_comb begin
    streak_d = streak_q;
    if (grant_i_entry) begin
      streak_d = '0;
    end else if (grant_d_entry) begin
      // Only data grants that actually made a fetch wait count toward the streak.
      if (!i_req) begin
        streak_d = '0;
      end else if (streak_q < STREAK_MAX) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign streak = streak_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single memory port between instruction fetch and data access.
// Data has priority except after MAX_D_STREAK consecutive data grants that
// made a fetch wait. A grant with no mem_ack for TIMEOUT cycles is aborted
// and completed with err and zero read data.
//   clk, rst                         : clock, asynchronous active-low reset
//   i_req, i_addr                    : fetch request (level) and word address
//   i_rdata, i_done                  : fetched word, one-cycle completion
//   d_req, d_we, d_addr, d_wdata     : data request (level), store flag, address, store data
//   d_rdata, d_done                  : load data, one-cycle completion
//   mem_req, mem_we, mem_addr,
//   mem_wdata                        : memory request towards the memory
//   mem_rdata, mem_ack               : memory read data and one-cycle completion
//   err                              : pulses with the done of a timed-out transfer
//   stall                            : pipeline hold while any request is unfinished
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err,
  output logic        stall
);

  localparam int unsigned         TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_e          state_q, state_d;
  arb_port_e           port_q, port_d;
  logic [15:0]         addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [15:0]         i_rdata_q, i_rdata_d;
  logic [15:0]         d_rdata_q, d_rdata_d;
  logic                err_q, err_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  logic                grant_i_entry;
  logic                grant_d_entry;
  logic [STREAK_W-1:0] streak;

  arb_fairness_ctr #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_fairness (
    .clk           (clk),
    .rst           (rst),
    .grant_i_entry (grant_i_entry),
    .grant_d_entry (grant_d_entry),
    .i_req         (i_req),
    .streak        (streak)
  );

  always_comb begin
    state_d       = state_q;
    port_d        = port_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    err_d         = 1'b0;
    tmo_d         = tmo_q;
    grant_i_entry = 1'b0;
    grant_d_entry = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (d_req && !(i_req && (streak == STREAK_MAX))) begin
          state_d       = ST_GRANT_D;
          port_d        = PORT_D;
          addr_d        = d_addr;
          wdata_d       = d_wdata;
          we_d          = d_we;
          tmo_d         = '0;
          grant_d_entry = 1'b1;
        end else if (i_req) begin
          state_d       = ST_GRANT_I;
          port_d        = PORT_I;
          addr_d        = i_addr;
          wdata_d       = '0;
          we_d          = 1'b0;
          tmo_d         = '0;
          grant_i_entry = 1'b1;
        end
      end

      ST_GRANT_I, ST_GRANT_D: begin
        // An ack on the terminal timeout cycle wins over the abort.
        if (mem_ack) begin
          state_d = ST_RESP;
          if (port_q == PORT_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            i_rdata_d = mem_rdata;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          tmo_d   = tmo_q + TMO_W'(1);
          if (port_q == PORT_D) begin
            d_rdata_d = '0;
          end else begin
            i_rdata_d = '0;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      port_q    <= PORT_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign mem_req   = (state_q == ST_GRANT_I) || (state_q == ST_GRANT_D);
  assign mem_we    = (state_q == ST_GRANT_D) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = (state_q == ST_RESP) && (port_q == PORT_I);
  assign d_done    = (state_q == ST_RESP) && (port_q == PORT_D);
  assign err       = err_q;
  assign stall     = (i_req & ~i_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 15;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        err;
  logic        stall;

  mem_arbiter #(
    .MAX_D_STREAK (MAXS),
    .TIMEOUT      (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Request levels as the arbiter saw them at the most recent rising edge.
  logic i_seen = 1'b0;
  logic d_seen = 1'b0;
  always @(posedge clk) begin
    i_seen <= i_req;
    d_seen <= d_req;
  end

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_i[$];
  exp_t sb_d[$];
  bit   grant_log[$];       // 1 = data grant, 0 = fetch grant
  int   exp_done[2];        // expected done cycle per port (0 = fetch, 1 = data)

  logic [15:0] mem_arr [int];

  bit rand_mode = 1'b0;
  int knob_lat  = 0;
  bit knob_to   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
    return a ^ 16'hA5A5;
  endfunction

  // Memory responder and arbitration reference: decides each grant's outcome,
  // predicts which port must own it, and records the expected completion.
  initial begin : memory_model
    bit          busy;
    bit          g_d;
    bit          exp_d;
    bit          g_we;
    bit          plan_to;
    int          plan_lat;
    int          gcnt;
    int          streak_m;
    int          r;
    logic [15:0] g_addr;
    logic [15:0] g_wd;
    logic [15:0] plan_rd;
    exp_t        e;
    busy      = 1'b0;
    streak_m  = 0;
    gcnt      = 0;
    plan_lat  = 0;
    plan_to   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!rst) begin
        busy     = 1'b0;
        streak_m = 0;
        continue;
      end
      if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          gcnt = 0;
          if (!d_seen && !i_seen) flag_fail("grant_without_request");
          // Data wins unless a fetch has already waited through MAXS data grants.
          exp_d = d_seen && !(i_seen && streak_m == MAXS);
          if (exp_d) streak_m = i_seen ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
          else       streak_m = 0;
          g_d = exp_d;
          grant_log.push_back(g_d);
          check("grant_addr", 32'(mem_addr), 32'(g_d ? d_addr : i_addr));
          check("grant_we", 32'(mem_we), 32'(g_d ? d_we : 1'b0));
          if (g_d && d_we) check("grant_wdata", 32'(mem_wdata), 32'(d_wdata));
          g_addr = mem_addr;
          g_we   = mem_we;
          g_wd   = mem_wdata;
          if (rand_mode) begin
            r        = int'($urandom_range(0, 9));
            plan_to  = (r == 0);
            plan_lat = (r == 1) ? TMO - 1 : int'($urandom_range(0, 3));
          end else begin
            plan_to  = knob_to;
            plan_lat = knob_lat;
          end
          if (plan_to) begin
            plan_rd = 16'h0000;
            e.rdata = 16'h0000;
            e.err   = 1'b1;
            exp_done[int'(g_d)] = cyc + TMO;
          end else begin
            if (g_d && g_we) begin
              plan_rd = 16'($urandom);
              mem_arr[int'(g_addr)] = g_wd;
            end else begin
              plan_rd = mem_read(g_addr);
            end
            e.rdata = plan_rd;
            e.err   = 1'b0;
            exp_done[int'(g_d)] = cyc + plan_lat + 1;
          end
          if (g_d) sb_d.push_back(e);
          else     sb_i.push_back(e);
        end else begin
          check("hold_addr", 32'(mem_addr), 32'(g_addr));
          check("hold_we_wdata", 32'({mem_we, mem_wdata}), 32'({g_we, g_wd}));
        end
        if (!plan_to && gcnt == plan_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = plan_rd;
        end else begin
          mem_rdata = 16'($urandom);
        end
        gcnt++;
      end else begin
        if (busy) begin
          busy = 1'b0;
          check("grant_length", 32'(gcnt), 32'(plan_to ? TMO : plan_lat + 1));
        end
        // Acks outside a grant must be ignored by the arbiter.
        if (rand_mode && $urandom_range(0, 3) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = 16'($urandom);
        end
      end
    end
  end

  // Output monitor: pops the scoreboard whenever a completion is presented.
  initial begin : monitor
    logic [15:0] last_i;
    logic [15:0] last_d;
    exp_t        e;
    last_i = 16'h0000;
    last_d = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_i = 16'h0000;
        last_d = 16'h0000;
        check("rst_dones_err", 32'({i_done, d_done, err, mem_req}), 32'(0));
        continue;
      end
      check("stall", 32'(stall), 32'((i_req & ~i_done) | (d_req & ~d_done)));
      if (i_done && d_done) flag_fail("both_done");
      if (i_done) begin
        if (sb_i.size() == 0) begin
          flag_fail("unexpected_i_done");
        end else begin
          e = sb_i.pop_front();
          check("i_rdata", 32'(i_rdata), 32'(e.rdata));
          check("i_err", 32'(err), 32'(e.err));
          last_i = e.rdata;
        end
        check("i_done_mem_req", 32'(mem_req), 32'(0));
      end else begin
        check("i_rdata_hold", 32'(i_rdata), 32'(last_i));
      end
      if (d_done) begin
        if (sb_d.size() == 0) begin
          flag_fail("unexpected_d_done");
        end else begin
          e = sb_d.pop_front();
          check("d_rdata", 32'(d_rdata), 32'(e.rdata));
          check("d_err", 32'(err), 32'(e.err));
          last_d = e.rdata;
        end
        check("d_done_mem_req", 32'(mem_req), 32'(0));
      end else begin
        check("d_rdata_hold", 32'(d_rdata), 32'(last_d));
      end
      if (!i_done && !d_done) check("err_without_done", 32'(err), 32'(0));
    end
  end

  // One transfer on one port. Raised #1 after a rising edge; after done the
  // request is either dropped or kept high with new attributes in the idle cycle.
  task automatic do_xfer(input bit is_d, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input bit keep, input int gap,
                         output int t_raise, output int t_done);
    bit got;
    int waited;
    if (is_d) begin
      d_addr  = addr;
      d_wdata = wdata;
      d_we    = we;
      d_req   = 1'b1;
    end else begin
      i_addr = addr;
      i_req  = 1'b1;
    end
    t_raise = cyc;
    t_done  = -1;
    got     = 1'b0;
    waited  = 0;
    while (!got && waited < 400) begin
      @(negedge clk);
      if (is_d ? d_done : i_done) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      flag_fail(is_d ? "d_done_timeout" : "i_done_timeout");
    end else begin
      t_done = cyc;
      check(is_d ? "d_done_cycle" : "i_done_cycle", 32'(t_done), 32'(exp_done[int'(is_d)]));
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      if (is_d) d_req = 1'b0;
      else      i_req = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  int tr;
  int td;
  bit bg_done;
  int bg_tr;
  int bg_td;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst     = 1'b0;
    i_req   = 1'b0;
    i_addr  = 16'h0000;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 16'h0000;
    d_wdata = 16'h0000;
    repeat (2) @(negedge clk);

    check("rst_mem_req",   32'(mem_req),   32'(0));
    check("rst_mem_we",    32'(mem_we),    32'(0));
    check("rst_i_done",    32'(i_done),    32'(0));
    check("rst_d_done",    32'(d_done),    32'(0));
    check("rst_err",       32'(err),       32'(0));
    check("rst_mem_addr",  32'(mem_addr),  32'(16'h0000));
    check("rst_mem_wdata", 32'(mem_wdata), 32'(16'h0000));
    check("rst_i_rdata",   32'(i_rdata),   32'(16'h0000));
    check("rst_d_rdata",   32'(d_rdata),   32'(16'h0000));
    check("rst_stall",     32'(stall),     32'(0));
    #2 rst = 1'b1;

    // Load with immediate ack, issued in the first cycle after reset release.
    mem_arr[int'(16'h0010)] = 16'hBEEF;
    knob_lat = 0;
    knob_to  = 1'b0;
    @(posedge clk);
    #1;
    do_xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 0, tr, td);
    check("load_latency", 32'(td - tr), 32'(2));
    check("load_rdata", 32'(d_rdata), 32'(16'hBEEF));

    // Store acked on the fourth grant cycle.
    knob_lat = 3;
    do_xfer(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1, tr, td);
    check("store_latency", 32'(td - tr), 32'(5));

    // Fetch, then a fetch that times out, then a normal fetch.
    knob_lat = 0;
    do_xfer(1'b0, 1'b0, 16'h0030, 16'h0000, 1'b0, 0, tr, td);
    check("fetch_rdata", 32'(i_rdata), 32'(16'h0030 ^ 16'hA5A5));
    knob_to = 1'b1;
    do_xfer(1'b0, 1'b0, 16'h0031, 16'h0000, 1'b0, 0, tr, td);
    check("timeout_latency", 32'(td - tr), 32'(1 + TMO));
    check("timeout_i_rdata", 32'(i_rdata), 32'(16'h0000));
    knob_to = 1'b0;
    do_xfer(1'b0, 1'b0, 16'h0032, 16'h0000, 1'b0, 0, tr, td);
    check("post_timeout_latency", 32'(td - tr), 32'(2));

    // Both requesters held continuously: four data grants, then one fetch.
    grant_log.delete();
    fork
      begin
        int a;
        int b;
        for (int k = 0; k < 8; k++)
          do_xfer(1'b1, 1'b0, 16'(16'h0100 + k), 16'h0000, (k < 7), 0, a, b);
      end
      begin
        int a;
        int b;
        for (int k = 0; k < 2; k++)
          do_xfer(1'b0, 1'b0, 16'(16'h0200 + k), 16'h0000, (k < 1), 0, a, b);
      end
    join
    check("order_len", 32'(grant_log.size()), 32'(10));
    for (int k = 0; k < 10 && k < grant_log.size(); k++)
      check($sformatf("order_%0d", k), 32'(grant_log[k]), 32'((k % 5) != 4));

    // Reset during a fetch grant: transfer abandoned, held request regranted.
    knob_to = 1'b1;
    bg_done = 1'b0;
    fork
      begin
        do_xfer(1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 0, bg_tr, bg_td);
        bg_done = 1'b1;
      end
    join_none
    begin
      int w;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!mem_req && w < 20);
    end
    check("pre_rst_mem_req", 32'(mem_req), 32'(1));
    #2 rst = 1'b0;
    #1;
    check("rst_async_mem_req", 32'(mem_req), 32'(0));
    check("rst_async_mem_addr", 32'(mem_addr), 32'(16'h0000));
    sb_i.delete();
    knob_to  = 1'b0;
    knob_lat = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("regrant_mem_req", 32'(mem_req), 32'(1));
    check("regrant_mem_addr", 32'(mem_addr), 32'(16'h0040));
    begin
      int w;
      w = 0;
      while (!bg_done && w < 100) begin
        @(negedge clk);
        w++;
      end
    end
    check("regrant_completed", 32'(bg_done), 32'(1));
    @(posedge clk);
    #1;

    // Randomized traffic on both ports with random latencies, timeouts and stray acks.
    rand_mode = 1'b1;
    fork
      begin
        int a;
        int b;
        int g;
        for (int k = 0; k < 30; k++) begin
          g = int'($urandom_range(0, 3));
          do_xfer(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)),
                  16'($urandom), (g == 0) && (k < 29), g, a, b);
        end
      end
      begin
        int a;
        int b;
        int g;
        for (int k = 0; k < 30; k++) begin
          g = int'($urandom_range(0, 3));
          do_xfer(1'b0, 1'b0, 16'($urandom_range(0, 31)), 16'h0000,
                  (g == 0) && (k < 29), g, a, b);
        end
      end
    join
    rand_mode = 1'b0;
    repeat (4) @(negedge clk);
    check("sb_i_drained", 32'(sb_i.size()), 32'(0));
    check("sb_d_drained", 32'(sb_d.size()), 32'(0));
    check("final_mem_req", 32'(mem_req), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
